// File: rtl/mac_acc_n.sv
// mac_acc_n: batched signed multiply-accumulate over N accepted samples.
// A go pulse in IDLE opens a batch. Each accepted d*p product is registered
// in stage 1 and summed into the accumulator in stage 2. The final sum is
// published on result with a one-cycle res_valid pulse.
// Optional feature macro: MAC_ACC_SAT_EN. When defined, every accumulation
// saturates and a batch-sticky overflow flag appears on ovf. When undefined,
// accumulation wraps and ovf is tied low.
module mac_acc_n #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int N     = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    d,
  input  logic signed [CW-1:0]    p,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    res_valid,
  output logic signed [ACC_W-1:0] result,
  output logic                    ovf
);

  localparam int PW    = DW + CW;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_first_q, s1_first_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] result_q, result_d;
  logic                    res_valid_q, res_valid_d;

  logic                    accept;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_next;

  assign accept    = (state_q == S_ACC) && in_valid;
  assign in_ready  = (state_q == S_ACC);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign result    = result_q;

  // The first product of a batch starts from zero instead of the stale sum.
  assign acc_base = s1_first_q ? '0 : acc_q;
  assign prod_ext = ACC_W'(prod_q);

`ifdef MAC_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;
  logic           sat_hi;
  logic           sat_lo;
  logic           clip;
  logic           sticky_q, sticky_d;
  logic           sticky_next;
  logic           ovf_q, ovf_d;

  // One guard bit shows when the sum has left the representable range.
  always_comb begin
    sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
    sat_hi   = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
    sat_lo   =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
    clip     = sat_hi | sat_lo;
    if (sat_hi) begin
      sum_next = ACC_MAX;
    end else if (sat_lo) begin
      sum_next = ACC_MIN;
    end else begin
      sum_next = sum_wide[ACC_W-1:0];
    end
    sticky_next = (s1_first_q ? 1'b0 : sticky_q) | clip;
  end

  // The sticky flag follows stage 2, and ovf is captured together with result.
  always_comb begin
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    if (s1_valid_q) begin
      sticky_d = sticky_next;
    end
    if (state_q == S_DRAIN) begin
      ovf_d = sticky_next;
    end
  end

  // Registers for the overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Plain two's-complement accumulation wraps modulo 2^ACC_W.
  assign sum_next = acc_base + prod_ext;
  assign ovf      = 1'b0;
`endif

  // Batch sequencing: count accepted samples and move through IDLE, ACC and DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_ACC;
          cnt_d   = '0;
        end
      end
      S_ACC: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage 1 captures the product; stage 2 accumulates; DRAIN publishes the sum.
  always_comb begin
    prod_d      = prod_q;
    s1_valid_d  = accept;
    s1_first_d  = s1_first_q;
    acc_d       = acc_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    if (accept) begin
      prod_d     = PW'(d) * PW'(p);
      s1_first_d = (cnt_q == '0);
    end
    if (s1_valid_q) begin
      acc_d = sum_next;
    end
    if (state_q == S_DRAIN) begin
      result_d    = sum_next;
      res_valid_d = 1'b1;
    end
  end

  // State and datapath registers. Reset also cancels any batch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_n.sv
// tb_mac_acc_n: directed vectors for mac_acc_n with hand-computed sums.
// Three instances share the inputs: the default configuration, a narrow
// accumulator (ACC_W=16), and a single-product batch (N=1).
module tb_mac_acc_n;

  logic              clk;
  logic              rst;
  logic              go;
  logic              in_valid;
  logic signed [7:0] d;
  logic signed [7:0] p;

  logic               in_ready, busy, res_valid, ovf;
  logic signed [19:0] result;
  logic               in_ready16, busy16, res_valid16, ovf16;
  logic signed [15:0] result16;
  logic               in_ready1, busy1, res_valid1, ovf1;
  logic signed [19:0] result1;

  int vectors;
  int errors;
  int rv_count;
  logic signed [19:0] exp20;
  logic signed [15:0] exp16;
  logic               exp_ovf16;

  mac_acc_n dut (
    .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .d(d), .p(p),
    .in_ready(in_ready), .busy(busy), .res_valid(res_valid),
    .result(result), .ovf(ovf)
  );

  mac_acc_n #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .d(d), .p(p),
    .in_ready(in_ready16), .busy(busy16), .res_valid(res_valid16),
    .result(result16), .ovf(ovf16)
  );

  mac_acc_n #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .d(d), .p(p),
    .in_ready(in_ready1), .busy(busy1), .res_valid(res_valid1),
    .result(result1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  // Count res_valid pulses of the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (res_valid === 1'b1) rv_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic feed(input logic signed [7:0] dv, input logic signed [7:0] pv);
    in_valid = 1'b1;
    d = dv;
    p = pv;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    go = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (result !== 20'sd0) begin errors++; $display("[TB] FAIL reset_result got %0d want 0", result); end
    vectors++;
    if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got %b want 0", res_valid); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back();
    int rv0;
    rv0 = rv_count;
    start_batch();
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_acc_flags got ready=%b busy=%b want 1 1", in_ready, busy);
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; d = -8'sd100; p = -8'sd100;
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_drain got rv=%b busy=%b ready=%b want 0 1 0", res_valid, busy, in_ready);
    end
    step();
    exp20 = 20'sd80000;
    vectors++;
    if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_res_valid got %b want 1", res_valid); end
    vectors++;
    if (result !== exp20) begin errors++; $display("[TB] FAIL b2b_result got %0d want %0d", result, exp20); end
    vectors++;
    if (ovf !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf_busy got ovf=%b busy=%b want 0 0", ovf, busy); end
    step();
    vectors++;
    if (res_valid !== 1'b0 || result !== exp20) begin
      errors++; $display("[TB] FAIL b2b_hold got rv=%b result=%0d want 0 %0d", res_valid, result, exp20);
    end
    vectors++;
    if (rv_count - rv0 != 1) begin errors++; $display("[TB] FAIL b2b_pulses got %0d want 1", rv_count - rv0); end
  endtask

  task automatic test_gaps();
    int rv0;
    rv0 = rv_count;
    start_batch();
    for (int i = 0; i < 8; i++) begin
      feed(8'sd127, -8'sd128);
      if (i < 7) begin
        go = 1'b1;
        d = 8'sd55;
        step();
        go = 1'b0;
      end
    end
    step();
    exp20 = -20'sd130048;
    vectors++;
    if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL gaps_res_valid got %b want 1", res_valid); end
    vectors++;
    if (result !== exp20) begin errors++; $display("[TB] FAIL gaps_result got %0d want %0d", result, exp20); end
    step();
    step();
    vectors++;
    if (rv_count - rv0 != 1) begin errors++; $display("[TB] FAIL gaps_pulses got %0d want 1", rv_count - rv0); end
  endtask

  task automatic test_abort();
    int rv0;
    rv0 = rv_count;
    start_batch();
    go = 1'b1;
    for (int i = 0; i < 4; i++) feed(8'sd5, 8'sd5);
    go = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || result !== 20'sd0) begin
      errors++; $display("[TB] FAIL abort_idle got busy=%b ready=%b result=%0d want 0 0 0", busy, in_ready, result);
    end
    step();
    step();
    step();
    vectors++;
    if (rv_count != rv0) begin errors++; $display("[TB] FAIL abort_no_pulse got %0d want 0", rv_count - rv0); end
    start_batch();
    for (int i = 1; i <= 8; i++) feed(8'sd1, 8'(i));
    step();
    exp20 = 20'sd36;
    vectors++;
    if (res_valid !== 1'b1 || result !== exp20) begin
      errors++; $display("[TB] FAIL abort_next got rv=%b result=%0d want 1 %0d", res_valid, result, exp20);
    end
  endtask

  task automatic test_go_in_res_cycle();
    start_batch();
    for (int i = 0; i < 8; i++) feed(-8'sd1, 8'sd5);
    step();
    go = 1'b1;
    exp20 = -20'sd40;
    vectors++;
    if (res_valid !== 1'b1 || result !== exp20) begin
      errors++; $display("[TB] FAIL gores_first got rv=%b result=%0d want 1 %0d", res_valid, result, exp20);
    end
    step();
    go = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || result !== exp20) begin
      errors++; $display("[TB] FAIL gores_restart got ready=%b rv=%b result=%0d want 1 0 %0d", in_ready, res_valid, result, exp20);
    end
    for (int i = 0; i < 8; i++) feed(8'sd2, 8'sd3);
    step();
    exp20 = 20'sd48;
    vectors++;
    if (res_valid !== 1'b1 || result !== exp20) begin
      errors++; $display("[TB] FAIL gores_second got rv=%b result=%0d want 1 %0d", res_valid, result, exp20);
    end
  endtask

  task automatic test_acc16();
`ifdef MAC_ACC_SAT_EN
    exp16 = 16'sd32767;
    exp_ovf16 = 1'b1;
`else
    exp16 = 16'sd0;
    exp_ovf16 = 1'b0;
`endif
    step();
    start_batch();
    for (int i = 0; i < 8; i++) feed(-8'sd128, -8'sd128);
    step();
    vectors++;
    if (res_valid16 !== 1'b1 || result16 !== exp16) begin
      errors++; $display("[TB] FAIL acc16_result got rv=%b result=%0d want 1 %0d", res_valid16, result16, exp16);
    end
    vectors++;
    if (ovf16 !== exp_ovf16) begin errors++; $display("[TB] FAIL acc16_ovf got %b want %b", ovf16, exp_ovf16); end
    exp20 = 20'sd131072;
    vectors++;
    if (result !== exp20 || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL acc20_result got result=%0d ovf=%b want %0d 0", result, ovf, exp20);
    end
  endtask

  task automatic test_n1();
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_batch();
    feed(-8'sd7, 8'sd9);
    vectors++;
    if (res_valid1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("[TB] FAIL n1_drain got rv=%b busy=%b want 0 1", res_valid1, busy1);
    end
    step();
    exp20 = -20'sd63;
    vectors++;
    if (res_valid1 !== 1'b1 || result1 !== exp20) begin
      errors++; $display("[TB] FAIL n1_result got rv=%b result=%0d want 1 %0d", res_valid1, result1, exp20);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    go = 1'b0;
    in_valid = 1'b0;
    d = '0;
    p = '0;
    vectors = 0;
    errors = 0;
    rv_count = 0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_go_in_res_cycle();
    test_acc16();
    test_n1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
